// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: row readback from the matrix and the
// column drive / accepted-key outputs toward the operand-entry logic.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, gathers one
// frame of synchronized rows per full rotation and debounces press/release.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master kp
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASING} state_t;
  typedef enum logic [1:0] {CL_EMPTY, CL_SINGLE, CL_MULTI} frame_class_t;

  logic [3:0]       row_s1, row_s2;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [3:0]       col_q;
  logic [3:0]       acc [3];
  logic             sample, frame_end;

  assign sample    = (div == DIV_LAST);
  assign frame_end = sample && (col_idx == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain row_s1 straight into row_s2.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      div     <= '0;
      col_idx <= 2'd0;
      col_q   <= 4'b1110;
      // NOTE: the accumulators are a tiny register file, not RAM, so they are
      // reset to "no row low" to keep a partial frame from leaking past reset.
      acc[0]  <= 4'hF;
      acc[1]  <= 4'hF;
      acc[2]  <= 4'hF;
    end else begin
      row_s1 <= kp.row;
      row_s2 <= row_s1;
      if (sample) begin
        div     <= '0;
        col_idx <= col_idx + 2'd1;
        col_q   <= {col_q[2:0], col_q[3]};
        case (col_idx)
          2'd0:    acc[0] <= row_s2;
          2'd1:    acc[1] <= row_s2;
          2'd2:    acc[2] <= row_s2;
          default: ;
        endcase
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // Column 3 is classified straight from the synchronizer on its sample edge.
  logic [3:0][3:0] frame;
  logic [4:0]      n_low;
  logic [3:0]      hit_code;
  frame_class_t    fclass;

  // NOTE: every variable gets a default at the top of a combinational block so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    frame    = {row_s2, acc[2], acc[1], acc[0]};
    n_low    = '0;
    hit_code = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!frame[c][r]) begin
          n_low    = n_low + 5'd1;
          hit_code = 4'(c * 4 + r);
        end
      end
    end
    if (n_low == 5'd0)      fclass = CL_EMPTY;
    else if (n_low == 5'd1) fclass = CL_SINGLE;
    else                    fclass = CL_MULTI;
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       cand, cand_n;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             accept;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cand        <= cand_n;
      key_valid_q <= accept;
      if (accept) key_code_q <= hit_code;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (fclass == CL_SINGLE) begin
            cand_n = hit_code;
            if (DEBOUNCE == 1) begin
              accept  = 1'b1;
              state_n = PRESSED;
              cnt_n   = CNT_MAX;
            end else begin
              state_n = CONFIRM;
              cnt_n   = CNT_W'(1);
            end
          end
        end
        CONFIRM: begin
          if (fclass == CL_SINGLE && hit_code == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              accept  = 1'b1;
              state_n = PRESSED;
            end
          end else if (fclass == CL_SINGLE) begin
            cand_n = hit_code;
            cnt_n  = CNT_W'(1);
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        PRESSED: begin
          // Lockout: only a confirmed release re-arms acceptance.
          if (fclass == CL_EMPTY) begin
            if (DEBOUNCE == 1) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              state_n = RELEASING;
              cnt_n   = CNT_W'(1);
            end
          end
        end
        RELEASING: begin
          if (fclass == CL_EMPTY) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_n = IDLE;
              cnt_n   = '0;
            end
          end else begin
            state_n = PRESSED;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    kp.col       = col_q;
    kp.key_code  = key_code_q;
    kp.key_valid = key_valid_q;
    kp.key_held  = (state == PRESSED) || (state == RELEASING);
  end
endmodule
